// File: rtl/rand_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rand_req_arbiter                                                           |
// | Round-robin shared 16-bit Galois LFSR server with bounded mask-and-reject. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rand_req_arbiter #(
    parameter int          N_REQ     = 4,
    parameter logic [15:0] SEED      = 16'h5D09,
    parameter int          MAX_TRIES = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N_REQ-1:0]     REQ,
    input  logic [16*N_REQ-1:0]  BOUND,
    input  logic                 SEED_VLD,
    input  logic [15:0]          SEED_IN,
    output logic [N_REQ-1:0]     ACK,
    output logic [15:0]          RAND_OUT,
    output logic                 BUSY
);

    localparam int          IW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] c_lfsr_taps = 16'h6B8F;
    localparam logic [7:0]  c_last_try  = 8'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [15:0]      bnd_q, bnd_d;
    logic [15:0]      mask_q, mask_d;
    logic [7:0]       tries_q, tries_d;
    logic [15:0]      rand_q, rand_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             w_pick_vld;
    logic [IW-1:0]    w_pick;
    logic [15:0]      w_bsel;
    logic [15:0]      w_c;
    logic             w_fit;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IW'(sum);
    endfunction

    // All-ones mask covering every bit up to the highest set bit of v.
    function automatic logic [15:0] smear(input logic [15:0] v);
        logic [15:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

    // Walk downward so the nearest requester after last_q is the final writer.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (REQ[wrap_idx(last_q, i)]) begin
                w_pick_vld = 1'b1;
                w_pick     = wrap_idx(last_q, i);
            end
        end
    end

    assign w_bsel = BOUND[int'(w_pick)*16 +: 16];
    assign w_c    = lfsr_q & mask_q;
    assign w_fit  = (w_c < bnd_q);

    always_comb begin
        if (SEED_VLD) begin
            lfsr_d = (SEED_IN == 16'd0) ? SEED : SEED_IN;
        end else begin
            lfsr_d = {lfsr_q[14:0], 1'b0} ^ (lfsr_q[15] ? c_lfsr_taps : 16'h0000);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        bnd_d   = bnd_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        rand_d  = rand_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_pick_vld) begin
                    gnt_d   = w_pick;
                    bnd_d   = w_bsel;
                    mask_d  = smear(w_bsel - 16'd1);
                    tries_d = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (!REQ[gnt_q]) begin
                    state_d = S_IDLE;
                end else if ((bnd_q == 16'd0) || w_fit || (tries_q == c_last_try)) begin
                    // c < 2*BOUND, so a single subtraction folds a rejected value into range.
                    if (bnd_q == 16'd0)  rand_d = lfsr_q;
                    else if (w_fit)      rand_d = w_c;
                    else                 rand_d = w_c - bnd_q;
                    ack_d[gnt_q] = 1'b1;
                    last_d       = gnt_q;
                    state_d      = S_DONE;
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            gnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            bnd_q   <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            rand_q  <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            bnd_q   <= bnd_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
            rand_q  <= rand_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ACK      = ack_q;
    assign RAND_OUT = rand_q;
    assign BUSY     = busy_q;

endmodule
`default_nettype wire
